rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
- Sequential operand/result controller placed directly upstream and downstream of the 16-bit ripple-carry adder.
- Accepts operand pairs over a valid/ready handshake and drives them onto the adder's a/b/cin inputs.
- Holds those inputs stable for a fixed settle window that covers the gate-delay ripple, then captures sum/cout into registers.
- Keeps a running accumulator and presents each result over a valid/ready handshake.

Parameters:
- SETTLE, 16, cycles the adder inputs are held before sum/cout are sampled. Must be at least 1. The default of 16 covers the full ripple at a 20 ns clock.
- CNT_W, 5, width of the settle counter. Must satisfy 2^CNT_W > SETTLE.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  controller can accept an operand
- in_a  input  16  operand A; ignored when in_acc=1
- in_b  input  16  operand B
- in_cin  input  1  carry-in
- in_acc  input  1  1: use the accumulator register as operand A
- add_a  output  16  to adder a
- add_b  output  16  to adder b
- add_cin  output  1  to adder cin
- add_sum  input  16  from adder sum
- add_cout  input  1  from adder cout
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  16  captured sum
- out_cout  output  1  captured carry-out
- out_ovf  output  1  signed overflow of the captured result
- busy  output  1  high in WAIT or DONE

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=IDLE.
  - add_a, add_b, add_cin, out_sum, out_cout, out_ovf, out_valid, acc, cnt all 0.
  - in_ready=1 once rst_n is released.
- Reset mid-operation: the transaction is aborted, no result is produced and the accumulator is cleared.
- States: IDLE, WAIT, DONE. Encoding is free; busy = (state != IDLE).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: add_a <= in_acc ? acc : in_a; add_b <= in_b; add_cin <= in_cin; cnt <= SETTLE-1; go to WAIT.
- WAIT:
  - in_ready=0 and add_* held constant.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: out_sum <= add_sum; out_cout <= add_cout; acc <= add_sum; out_ovf <= (add_a[15]==add_b[15]) & (add_sum[15]!=add_a[15]); out_valid <= 1; go to DONE.
- Latency: operand accepted at edge T gives out_valid high after edge T+SETTLE, with exactly SETTLE cycles spent in WAIT.
- DONE:
  - in_ready=0 and out_* held stable.
  - On out_ready: out_valid <= 0 and go to IDLE.
  - out_ready while out_valid=0 has no effect.
- Throughput: one transaction at a time, no overlap. The next operand can be accepted no earlier than the cycle after the result handshake.
- in_valid while in_ready=0 is ignored; the producer holds it.
- Arithmetic:
  - Wrap-around is the adder's: 16'hFFFF + 1 gives sum 0, cout 1.
  - The accumulator keeps only the 16-bit sum; carry is not folded in.
- add_* change only on acceptance and remain at the last operands while IDLE.

Optional Feature:
- Macro RCA_SUB_EN.
- Defined:
  - Extra input port in_sub (1 bit).
  - On acceptance with in_sub=1: add_b <= ~in_b; add_cin <= 1, and in_cin is ignored.
  - out_cout=1 then means no borrow.
  - out_ovf uses the inverted add_b, so the same formula applies.
  - in_sub=0 behaves as plain add.
- Undefined: in_sub port absent; add only.

Test Plan:
- Reset, then a=16'h1234, b=16'h4321, cin=0, SETTLE=16 -> out_valid exactly 16 cycles after acceptance; sum=16'h5555, cout=0, ovf=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=1 -> sum=16'h8000, ovf=1.
- Accumulate: first a=10, b=5; then in_acc=1, in_a=999, b=7 -> results 15 then 22. in_a is ignored.
- Backpressure: out_ready=0 for 10 cycles -> out_* stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 the next cycle.
- rst_n pulsed low during WAIT -> out_valid stays 0, acc=0, and the next transaction is correct with nothing stale.
- RCA_SUB_EN: a=100, b=30, in_sub=1 -> sum=70, cout=1. a=30, b=100 -> sum=16'hFFBA, cout=0.

Source files
------------

// File: rtl/rca_seq_ctrl_if.sv
// Handshake and adder-side bus of the ripple-carry adder sequencing controller.
// in_sub exists only when RCA_SUB_EN is defined.
interface rca_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_cin;
   logic        in_acc;
`ifdef RCA_SUB_EN
   logic        in_sub;
`endif
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_cout;
   logic        out_ovf;

   // Controller view
   modport slave (
`ifdef RCA_SUB_EN
      input  in_sub,
`endif
      input  in_valid, in_a, in_b, in_cin, in_acc, add_sum, add_cout, out_ready,
      output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
   );

   // Producer, consumer and adder view
   modport master (
`ifdef RCA_SUB_EN
      output in_sub,
`endif
      output in_valid, in_a, in_b, in_cin, in_acc, add_sum, add_cout, out_ready,
      input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Operand/result sequencer around a 16-bit ripple-carry adder: hold inputs for SETTLE
// cycles, capture sum/cout, keep a 16-bit accumulator. RCA_SUB_EN adds in_sub (a - b).
module rca_seq_ctrl #(
   parameter int unsigned SETTLE = 16,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   rca_seq_ctrl_if.slave     bus,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [15:0]        acc_q;
   logic [15:0]        add_a_q;
   logic [15:0]        add_b_q;
   logic               add_cin_q;
   logic [15:0]        out_sum_q;
   logic               out_cout_q;
   logic               out_ovf_q;
   logic               out_valid_q;
   logic               in_ready_q;
   logic               busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  add_a_q <= bus.in_acc ? acc_q : bus.in_a;
`ifdef RCA_SUB_EN
                  // Subtract as a + ~b + 1; in_cin is irrelevant then.
                  add_b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
                  add_cin_q <= bus.in_sub | bus.in_cin;
`else
                  add_b_q   <= bus.in_b;
                  add_cin_q <= bus.in_cin;
`endif
                  cnt_q      <= CNT_W'(SETTLE - 1);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  out_sum_q   <= bus.add_sum;
                  out_cout_q  <= bus.add_cout;
                  acc_q       <= bus.add_sum;
                  out_ovf_q   <= (add_a_q[15] == add_b_q[15]) & (bus.add_sum[15] != add_a_q[15]);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_cin   = add_cin_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_ovf   = out_ovf_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed plus randomized bench for rca_seq_ctrl against an arithmetic reference model.
module tb_rca_seq_ctrl;
   localparam int unsigned SETTLE = 16;

   logic clk;
   logic rst_n;
   logic busy;
   int   tests;
   int   fails;
   logic [15:0] acc_m;
   logic [15:0] last_sum;
   logic        last_cout;
   logic        last_ovf;

   rca_seq_ctrl_if bus ();

   rca_seq_ctrl #(.SETTLE(SETTLE), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   // Ideal adder standing in for the ripple-carry block.
   assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic use_acc, input logic sub, input int unsigned bp);
      logic [15:0] opa;
      logic [15:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
      int          sres;
      int unsigned cyc;
      opa = use_acc ? acc_m : a;
      if (sub) begin
         exp_sum  = opa - b;
         exp_cout = (opa >= b);
         sres     = int'($signed(opa)) - int'($signed(b));
      end else begin
         {exp_cout, exp_sum} = {1'b0, opa} + {1'b0, b} + 17'(cin);
         sres = int'($signed(opa)) + int'($signed(b)) + int'(cin);
      end
      exp_ovf = (sres > 32767) || (sres < -32768);

      check("in_ready_idle", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_acc   = use_acc;
`ifdef RCA_SUB_EN
      bus.in_sub   = sub;
`endif
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      bus.in_cin   = 1'($urandom);
      bus.in_acc   = 1'($urandom);
      check("in_ready_wait", bus.in_ready, 0);
      check("busy_wait", busy, 1);
      check("add_a", bus.add_a, opa);
      check("add_b", bus.add_b, sub ? ~b : b);
      check("add_cin", bus.add_cin, sub ? 1'b1 : cin);

      cyc = 0;
      while (!bus.out_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, SETTLE);
      check("add_a_held", bus.add_a, opa);
      check("out_sum", bus.out_sum, exp_sum);
      check("out_cout", bus.out_cout, exp_cout);
      check("out_ovf", bus.out_ovf, exp_ovf);
      last_sum  = bus.out_sum;
      last_cout = bus.out_cout;
      last_ovf  = bus.out_ovf;

      for (int i = 0; i < int'(bp); i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         check("bp_sum", bus.out_sum, exp_sum);
         check("bp_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("valid_drop", bus.out_valid, 0);
      check("in_ready_back", bus.in_ready, 1);
      check("busy_idle", busy, 0);
      check("add_a_idle", bus.add_a, opa);
      acc_m = exp_sum;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      acc_m = '0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_acc    = 1'b0;
      bus.out_ready = 1'b0;
`ifdef RCA_SUB_EN
      bus.in_sub    = 1'b0;
`endif
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_add_a", bus.add_a, 0);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", bus.in_ready, 1);

      run_txn(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 0);
      check("plan_5555", last_sum, 16'h5555);
      run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
      check("wrap_sum", last_sum, 16'h0000);
      check("wrap_cout", last_cout, 1);
      run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
      check("ovf_sum", last_sum, 16'h8000);
      check("ovf_flag", last_ovf, 1);
      run_txn(16'd10, 16'd5, 1'b0, 1'b0, 1'b0, 0);
      run_txn(16'd999, 16'd7, 1'b0, 1'b1, 1'b0, 10);
      check("acc_22", last_sum, 16'd22);

      // Reset asserted while waiting on the adder.
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h00AA;
      bus.in_b     = 16'h0055;
      bus.in_acc   = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("abort_busy", busy, 0);
      check("abort_add_a", bus.add_a, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      acc_m = '0;
      repeat (SETTLE + 2) @(posedge clk);
      #1;
      check("abort_no_result", bus.out_valid, 0);
      run_txn(16'd999, 16'd7, 1'b0, 1'b1, 1'b0, 0);
      check("abort_acc_clear", last_sum, 16'd7);

`ifdef RCA_SUB_EN
      run_txn(16'd100, 16'd30, 1'b1, 1'b0, 1'b1, 0);
      check("sub_70", last_sum, 16'd70);
      check("sub_noborrow", last_cout, 1);
      run_txn(16'd30, 16'd100, 1'b0, 1'b0, 1'b1, 0);
      check("sub_neg", last_sum, 16'hFFBA);
      check("sub_borrow", last_cout, 0);
`endif

      for (int i = 0; i < 24; i++) begin
         logic sub_r;
`ifdef RCA_SUB_EN
         sub_r = 1'($urandom);
`else
         sub_r = 1'b0;
`endif
         run_txn(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), sub_r,
                 $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
